// File: rtl/msu_pkg.sv
// Shared constants and types for the modular squaring unit and its output normalization stage.
package msu_pkg;

  localparam int WordBits     = 16;
  localparam int NumElements  = 3;
  localparam int FullWordBits = WordBits + 1;
  localparam int TargetBits   = 32;
  localparam int UpperTriBits = 18;

  localparam logic [TargetBits-1:0] Modulus = 32'hd82c07cd;

  typedef logic [UpperTriBits-1:0][TargetBits-1:0] redTable_t;

  // Entry j is 2^(TargetBits+j) mod Modulus, the weight of upper bit j folded into the low word.
  function automatic redTable_t genRedTable();
    redTable_t   t;
    logic [63:0] p;
    for (int j = 0; j < UpperTriBits; j++) begin
      p    = (64'd1 << (TargetBits + j)) % {32'd0, Modulus};
      t[j] = p[TargetBits-1:0];
    end
    return t;
  endfunction

  localparam redTable_t UpperRedTable = genRedTable();

  localparam int RedOutFoldBits = WordBits + 2;
  localparam int RedOutAccBits  = TargetBits + $clog2(RedOutFoldBits + 1) + 1;

  typedef logic [NumElements-1:0][FullWordBits-1:0] redCoeffs_t;

  typedef enum logic [2:0] {IDLE, CARRY, FOLD, SUB, DONE} red_out_state_e;

endpackage

// File: rtl/msu_red_out_csub.sv
// Combinational compare-and-subtract of Modulus against the reduction accumulator.
module msu_red_out_csub
  import msu_pkg::*;
(
  input  logic [RedOutAccBits-1:0] acc,
  output logic [RedOutAccBits-1:0] diff,
  output logic                     ge
);

  localparam logic [RedOutAccBits-1:0] ModExt = RedOutAccBits'(Modulus);

  assign ge   = (acc >= ModExt);
  assign diff = acc - ModExt;

endmodule

// File: rtl/msu_reduce_out.sv
// Serial carry propagation, upper-bit fold and bounded subtraction to the canonical residue.
// Optional build macro MSU_REDUCE_OUT_EARLY_EXIT_EN skips fold cycles once the remaining upper bits are zero.
module msu_reduce_out
  import msu_pkg::*;
#(
  parameter int MaxSubtracts = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     sq_valid_i,
  output logic                                     sq_ready_o,
  input  logic [NumElements-1:0][FullWordBits-1:0] sq_i,
  output logic                                     res_valid_o,
  input  logic                                     res_ready_i,
  output logic [TargetBits-1:0]                    res_o,
  output logic                                     err_o
);

  localparam int FoldBits = RedOutFoldBits;
  localparam int AccBits  = RedOutAccBits;
  localparam int VBits    = NumElements * WordBits + 2;
  localparam int KBits    = (NumElements > 1) ? $clog2(NumElements) : 1;
  localparam int JBits    = (FoldBits > 1) ? $clog2(FoldBits) : 1;
  localparam int NBits    = $clog2(MaxSubtracts + 1);

  if (FoldBits > UpperTriBits) begin : gFoldCheck
    $error("FoldBits exceeds the reduction table depth");
  end

  red_out_state_e state, stateNext;

  logic [NumElements-1:0][FullWordBits-1:0] coeffReg;
  logic [1:0]               carryReg;
  logic [KBits-1:0]         kReg;
  logic [VBits-1:0]         vReg;
  logic [FoldBits-1:0]      upperReg;
  logic [JBits-1:0]         jReg;
  logic [AccBits-1:0]       accReg;
  logic [NBits-1:0]         nReg;
  logic [TargetBits-1:0]    resReg;
  logic                     errReg;

  logic [FullWordBits:0]    sumK;
  logic [1:0]               carryNext;
  logic [VBits-1:0]         vNext;
  logic [FoldBits-1:0]      upperNext;
  logic [AccBits-1:0]       foldAddend;
  logic [AccBits-1:0]       diff;
  logic                     ge;
  logic                     lastElem;
  logic                     lastFold;
  logic                     subLimit;

  msu_red_out_csub uCsub (
    .acc  (accReg),
    .diff (diff),
    .ge   (ge)
  );

  // The final carry lands in the top two bits of V once the last element has been absorbed.
  always_comb begin
    sumK      = {1'b0, coeffReg[kReg]} + {{(FullWordBits-1){1'b0}}, carryReg};
    carryNext = sumK[WordBits +: 2];
    lastElem  = (kReg == KBits'(NumElements - 1));
    lastFold  = (jReg == JBits'(FoldBits - 1));
    subLimit  = (nReg == NBits'(MaxSubtracts));
    vNext     = vReg;
    vNext[kReg*WordBits +: WordBits] = sumK[WordBits-1:0];
    if (lastElem)
      vNext[VBits-1 -: 2] = carryNext;
    upperNext  = vNext[TargetBits +: FoldBits];
    foldAddend = upperReg[0] ? {{(AccBits-TargetBits){1'b0}}, UpperRedTable[jReg]} : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (sq_valid_i) stateNext = CARRY;
      CARRY: begin
        if (lastElem) begin
`ifdef MSU_REDUCE_OUT_EARLY_EXIT_EN
          stateNext = (upperNext == '0) ? SUB : FOLD;
`else
          stateNext = FOLD;
`endif
        end
      end
      FOLD: begin
`ifdef MSU_REDUCE_OUT_EARLY_EXIT_EN
        if (lastFold || ((upperReg >> 1) == '0)) stateNext = SUB;
`else
        if (lastFold) stateNext = SUB;
`endif
      end
      SUB:   if (!ge || subLimit) stateNext = DONE;
      DONE:  if (res_ready_i) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath registers advance alongside the state register; a reset drops any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      coeffReg <= '0;
      carryReg <= '0;
      kReg     <= '0;
      vReg     <= '0;
      upperReg <= '0;
      jReg     <= '0;
      accReg   <= '0;
      nReg     <= '0;
      resReg   <= '0;
      errReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sq_valid_i) begin
            coeffReg <= sq_i;
            errReg   <= 1'b0;
            carryReg <= '0;
            kReg     <= '0;
            vReg     <= '0;
          end
        end
        CARRY: begin
          vReg     <= vNext;
          carryReg <= carryNext;
          kReg     <= kReg + 1'b1;
          if (lastElem) begin
            accReg   <= {{(AccBits-TargetBits){1'b0}}, vNext[TargetBits-1:0]};
            upperReg <= upperNext;
            jReg     <= '0;
            nReg     <= '0;
          end
        end
        FOLD: begin
          accReg   <= accReg + foldAddend;
          upperReg <= upperReg >> 1;
          jReg     <= jReg + 1'b1;
        end
        SUB: begin
          if (ge && !subLimit) begin
            accReg <= diff;
            nReg   <= nReg + 1'b1;
          end else begin
            resReg <= accReg[TargetBits-1:0];
            if (ge) errReg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sq_ready_o  = (state == IDLE);
  assign res_valid_o = (state == DONE);
  assign res_o       = resReg;
  assign err_o       = errReg;

endmodule

// File: tb/tb_msu_reduce_out.sv
// Randomized self-checking bench for msu_reduce_out against an arithmetic V mod Modulus model.
module tb_msu_reduce_out;
  import msu_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  sq_valid_i;
  logic                  sq_ready_o;
  redCoeffs_t            sq_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [TargetBits-1:0] res_o;
  logic                  err_o;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  msu_reduce_out dut (
    .clk         (clk),
    .reset       (reset),
    .sq_valid_i  (sq_valid_i),
    .sq_ready_o  (sq_ready_o),
    .sq_i        (sq_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_o       (res_o),
    .err_o       (err_o)
  );

  task automatic checkOutput(input string tag, input longint unsigned observed,
                             input longint unsigned expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic longint unsigned valueOf(input redCoeffs_t c);
    longint unsigned v = 0;
    for (int k = 0; k < NumElements; k++)
      v += longint'(c[k]) << (WordBits * k);
    return v;
  endfunction

  // Accumulator after folding: low TargetBits of V plus the residue weight of every set upper bit.
  function automatic longint unsigned foldedAcc(input longint unsigned v);
    longint unsigned acc = v % (64'd1 << TargetBits);
    for (int j = 0; j < RedOutFoldBits; j++)
      if (((v >> (TargetBits + j)) & 64'd1) != 0)
        acc += (64'd1 << (TargetBits + j)) % longint'(Modulus);
    return acc;
  endfunction

  function automatic int expectedLatency(input longint unsigned v);
    int foldCycles = RedOutFoldBits;
    int subtracts  = int'(foldedAcc(v) / longint'(Modulus));
`ifdef MSU_REDUCE_OUT_EARLY_EXIT_EN
    longint unsigned upper = v >> TargetBits;
    foldCycles = 0;
    for (int j = 0; j < RedOutFoldBits; j++)
      if (((upper >> j) & 64'd1) != 0) foldCycles = j + 1;
`endif
    return 1 + NumElements + foldCycles + subtracts + 1;
  endfunction

  task automatic applyStimulus(input redCoeffs_t c, input int holdCycles);
    longint unsigned v      = valueOf(c);
    longint unsigned expRes = v % longint'(Modulus);
    int              cycles;
    @(negedge clk);
    sq_i       = c;
    sq_valid_i = 1'b1;
    @(posedge clk);
    #1;
    sq_valid_i = 1'b0;
    checkOutput("acceptReady", sq_ready_o, 0);
    cycles = 1;
    while (!res_valid_o && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("latency", cycles, expectedLatency(v));
    checkOutput("res", res_o, expRes);
    checkOutput("err", err_o, 0);
    for (int i = 0; i < holdCycles; i++) begin
      sq_valid_i = 1'b1;
      sq_i       = ~c;
      @(posedge clk);
      #1;
      checkOutput("holdRes", res_o, expRes);
      checkOutput("holdValid", res_valid_o, 1);
      checkOutput("holdReady", sq_ready_o, 0);
    end
    sq_valid_i  = 1'b0;
    res_ready_i = 1'b1;
    @(posedge clk);
    #1;
    res_ready_i = 1'b0;
    checkOutput("validDrop", res_valid_o, 0);
    checkOutput("readyRise", sq_ready_o, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    redCoeffs_t c;
    reset       = 1'b1;
    sq_valid_i  = 1'b0;
    res_ready_i = 1'b0;
    sq_i        = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", sq_ready_o, 1);
    checkOutput("rstValid", res_valid_o, 0);
    checkOutput("rstRes", res_o, 0);
    checkOutput("rstErr", err_o, 0);
    @(negedge clk);
    reset = 1'b0;

    c = '0;
    applyStimulus(c, 0);
    c = '0; c[0] = 17'd1;
    applyStimulus(c, 0);
    c = '0; c[0] = 17'h07cd; c[1] = 17'hd82c;
    applyStimulus(c, 1);
    c = '0; c[2] = 17'd1;
    applyStimulus(c, 0);
    c = {NumElements{17'h1ffff}};
    applyStimulus(c, 10);

    // Abort a job while it is folding, then confirm a fresh job runs cleanly.
    @(negedge clk);
    sq_i       = {NumElements{17'h1ffff}};
    sq_valid_i = 1'b1;
    @(posedge clk);
    #1;
    sq_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midRstReady", sq_ready_o, 1);
    checkOutput("midRstValid", res_valid_o, 0);
    checkOutput("midRstRes", res_o, 0);
    @(negedge clk);
    reset = 1'b0;
    c = '0; c[0] = 17'h1234; c[1] = 17'h1abcd; c[2] = 17'h0ff00;
    applyStimulus(c, 0);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NumElements; k++)
        c[k] = FullWordBits'($urandom_range(0, 17'h1ffff));
      if (t % 8 == 0) c[NumElements-1] = 17'h1ffff;
      applyStimulus(c, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/msu_reduce_out.md
Name: msu_reduce_out

Overview:
Output normalization stage downstream of the modular squaring unit.
- Input: one squaring result in redundant form. That is NumElements coefficients, each FullWordBits wide, with value V = sum(coeff_k * 2^(WordBits*k)).
- Output: the canonical residue V mod Modulus, TargetBits wide, for readout and software compare.
- Method, multi-cycle: serial carry propagation, then fold of the upper bits through msu_pkg::UpperRedTable, then bounded conditional subtraction.

Parameters:
WordBits, msu_pkg::WordBits, width of the non-redundant part of each coefficient
NumElements, msu_pkg::NumElements, number of input coefficients
TargetBits, msu_pkg::TargetBits, output width and modulus width
FoldBits, WordBits+2, bits of the propagated value at or above TargetBits; must be <= msu_pkg::UpperTriBits (elaboration assertion)
MaxSubtracts, 32, subtract-iteration limit before err_o is raised

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
sq_valid_i  input  1  redundant input valid
sq_ready_o  output  1  block can accept an input (high only in IDLE)
sq_i  input  NumElements x FullWordBits  redundant coefficients, element 0 least significant
res_valid_o  output  1  result valid
res_ready_i  input  1  consumer accepts the result
res_o  output  TargetBits  canonical residue, value < Modulus
err_o  output  1  subtract limit exceeded; sticky until next accept

Behaviour:
- Reset: state=IDLE; sq_ready_o=1; res_valid_o=0; res_o=0; err_o=0; all counters and accumulators cleared.
- A reset asserted mid-operation discards the job; no partial result is ever emitted.
- IDLE:
  - On sq_valid_i && sq_ready_o, capture sq_i into a register and clear err_o.
  - carry=0, k=0 -> CARRY.
- CARRY, NumElements cycles, one element per cycle:
  - s = coeff_k + carry.
  - V word k = s[WordBits-1:0]; carry = s >> WordBits. carry is 2 bits, max value 2.
  - After the last element, the final carry goes into the top 2 bits. V width = NumElements*WordBits + 2.
  - Set acc = V[TargetBits-1:0], j=0 -> FOLD.
- FOLD, FoldBits cycles, one bit per cycle:
  - If V[TargetBits+j] is set, acc += UpperRedTable[j].
  - acc width = TargetBits + clog2(FoldBits+1) + 1. It never overflows, because acc < 2^TargetBits + FoldBits*Modulus.
  - After j = FoldBits-1 -> SUB with n=0.
- SUB, one compare/subtract per cycle:
  - If acc >= Modulus: acc -= Modulus, n++.
  - Otherwise: res_o = acc[TargetBits-1:0] -> DONE.
  - If n reaches MaxSubtracts with acc still >= Modulus: err_o=1, res_o = acc truncated -> DONE.
- DONE:
  - res_valid_o=1; res_o stable while res_valid_o && !res_ready_i.
  - On res_ready_i: res_valid_o=0 -> IDLE, and sq_ready_o rises the next cycle.
- No pipelining: one job in flight; no input is accepted before the result is handshaken.
- Latency, accept to res_valid_o: 1 + NumElements + FoldBits + (n+1) cycles.
- Simultaneous events: sq_valid_i is ignored in all states except IDLE. res_ready_i is ignored while res_valid_o=0.

Optional Feature:
MSU_REDUCE_OUT_EARLY_EXIT_EN
- Defined: FOLD exits to SUB as soon as the remaining bits V[TargetBits+FoldBits-1 : TargetBits+j] are all zero. If all upper bits are zero, FOLD takes 0 cycles, because CARRY goes directly to SUB. Latency then depends on the data.
- Undefined: FOLD always takes exactly FoldBits cycles.
- res_o is identical in both builds.

Decomposition:
- Add to msu_pkg:
  - typedef redundant coefficient array (NumElements x FullWordBits)
  - constant RedOutAccBits
  - constant RedOutFoldBits
  - enum red_out_state_e {IDLE, CARRY, FOLD, SUB, DONE}
- Reuse msu_pkg Modulus and UpperRedTable unchanged.
- Sub-module msu_red_out_csub: combinational compare-and-subtract of Modulus on acc. It returns the difference and a ge flag, so that SUB can be timed separately.

Test Plan (config WordBits=16, WordElements=2, NumElements=3, TargetBits=32, Modulus=32'hd82c07cd):
- All coefficients 0 -> res_o=0, err_o=0. Latency 1+3+18+1=23 cycles (early-exit build: 5).
- coeff0=1, rest 0 -> res_o=32'h00000001.
- coeff0=16'h07cd, coeff1=16'hd82c -> value = Modulus -> res_o=0, exactly one subtract.
- coeff2=1 (2^32) -> res_o=32'h27d3f833.
- All coefficients 17'h1ffff -> res_o equals the golden model of V mod Modulus. Also: hold res_ready_i=0 for 10 cycles -> res_o stable, sq_ready_o=0, and a new sq_valid_i is ignored.
- Assert reset during FOLD -> next cycle: IDLE, sq_ready_o=1, res_valid_o=0. A following job completes correctly.
